// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_adder.sv
// Plain WIDTH-bit ripple/carry adder with carry-in and carry-out.
module seq_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/shift_add_mul_seq.sv
// Unsigned WIDTH x WIDTH sequential multiplier: one add-and-shift step per cycle,
// fixed WIDTH-cycle run, abortable, with a registered 2*WIDTH product.
module shift_add_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    assign w_addend  = r_acc_lo[0] ? r_mcand : '0;
    // Carry-out becomes the new top bit; the low half shifts in the add's LSB.
    assign w_acc_nxt = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

    seq_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (r_acc_hi),
        .y    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_load = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_step = (r_state == ST_RUN) && !abort;
    assign w_last = w_step && (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                 w_state_nxt = ST_IDLE;
                else if (r_count == LAST)  w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == ST_RUN);
        done    = (r_state == ST_DONE);
        product = r_product;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_count  <= '0;
        end else if (w_step) begin
            {r_acc_hi, r_acc_lo} <= w_acc_nxt;
            r_count              <= r_count + CW'(1);
            if (w_last) begin
                r_product <= w_acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Scoreboard bench: stimulus queues expected products and done cycles, monitor checks on done.
module tb_shift_add_mul_seq;

    localparam int unsigned W = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     product;

    typedef struct packed {
        logic [63:0] prod;
        logic [63:0] due;
        logic [31:0] tag;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] cyc = '0;
    int          busy_run = 0;
    logic        prev_done = 1'b0;
    int          tag_n = 0;

    shift_add_mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_run++;
            if (done) begin
                check("done_single_cycle", {127'd0, prev_done}, 128'd0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with product 0x%0h, required no done", product);
                end else begin
                    m_e = q.pop_front();
                    check($sformatf("product_t%0d", m_e.tag), {64'd0, product}, {64'd0, m_e.prod});
                    check($sformatf("latency_t%0d", m_e.tag), {64'd0, cyc}, {64'd0, m_e.due});
                    check($sformatf("busy_cycles_t%0d", m_e.tag), 128'(busy_run), 128'(W));
                end
                busy_run = 0;
            end else if (!busy) begin
                busy_run = 0;
            end
            prev_done = done;
        end else begin
            busy_run  = 0;
            prev_done = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [2*W-1:0] p);
        exp_t e;
        e.prod = p;
        e.due  = cyc + 64'(W) + 64'd1;
        e.tag  = 32'(tag_n);
        tag_n++;
        q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] p);
        a     = ia;
        b     = ib;
        start = 1'b1;
        push_exp(p);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", {127'd0, done}, 128'd1);
    endtask

    logic [W-1:0]   va [6];
    logic [W-1:0]   vb [6];
    logic [2*W-1:0] vp [6];

    initial begin
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vp[0] = 64'hFFFF_FFFE_0000_0001;
        va[1] = 32'h0;         vb[1] = 32'h5;         vp[1] = 64'h0;
        va[2] = 32'h7;         vb[2] = 32'h0;         vp[2] = 64'h0;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'h1;         vp[3] = 64'h0000_0000_FFFF_FFFF;
        va[4] = 32'h8000_0000; vb[4] = 32'h2;         vp[4] = 64'h0000_0001_0000_0000;
        va[5] = 32'hDEAD_BEEF; vb[5] = 32'h10;        vp[5] = 64'h0000_000D_EADB_EEF0;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        #12;
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_product", {64'd0, product}, 128'd0);

        // Start presented together with reset release: first edge must accept it.
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd3, 32'd5, 64'hF);
        wait_done(60);
        tick(1);

        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vp[i]);
            wait_done(60);
            tick(1);
        end

        // Start during RUN is ignored.
        issue(32'd7, 32'd9, 64'h3F);
        tick(10);
        a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        tick(3);
        check("hold_after_done", {64'd0, product}, 128'h3F);

        // Abort mid-run keeps previous product and returns to IDLE.
        issue(32'd6, 32'd4, 64'h18);
        wait_done(60);
        tick(1);
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(5);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        check("abort_product", {64'd0, product}, 128'h18);
        tick(40);
        check("abort_product_later", {64'd0, product}, 128'h18);
        check("abort_idle", {127'd0, busy}, 128'd0);

        // Abort with start in IDLE: start wins.
        abort = 1'b1;
        issue(32'd3, 32'd4, 64'hC);
        abort = 1'b0;
        wait_done(60);
        tick(1);

        // Back-to-back: start held through DONE with new operands.
        a = 32'd12; b = 32'd11; start = 1'b1;
        push_exp(64'h84);
        @(negedge clk);
        a = 32'd10; b = 32'd10;
        wait_done(60);
        push_exp(64'h64);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {127'd0, busy}, 128'd1);
        wait_done(60);
        tick(1);

        // Asynchronous reset between edges, mid-run.
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {127'd0, busy}, 128'd0);
        check("async_rst_done", {127'd0, done}, 128'd0);
        check("async_rst_product", {64'd0, product}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(40);
        check("post_rst_idle", {127'd0, busy}, 128'd0);
        issue(32'd2, 32'd3, 64'd6);
        wait_done(60);
        tick(2);

        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
